// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port synchronous RAM.
//   Port 0 (CPU) and port 1 (DMA/loader) compete for one RAM access per cycle.
//   The grant is combinational from the requests and registered owner/burst state.
//   A port keeps the RAM for at most BURST_MAX consecutive grants while the other
//   port is waiting. Read data comes back one cycle after a read grant, flagged
//   by that port's registered rvalid.
//
// Build option:
//   RAM_ARB_RR_EN  defined   : a tie from idle goes to the port not granted last
//                  undefined : a tie from idle always goes to port 0
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   m0_req/we/addr/wdata -> m0_gnt   port 0 request, accepted in the same cycle
//   m0_rvalid                        port 0 read data valid (cycle after read grant)
//   m1_*                             same as port 0, for port 1
//   rdata                            shared read data (pass-through of ram_dout)
//   ram_addr/ram_din/ram_we          RAM request side, driven by the granted port
//   ram_dout                         RAM registered read data
module ram_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_P0,
    OWN_P1
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic          gnt0, gnt1;
  logic          pick0, pick1;
  logic          reselect;

`ifdef RAM_ARB_RR_EN
  logic last_q, last_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
`ifdef RAM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Next-state and grant decision
  always_comb begin
    // Choice used from idle, or when the current owner drops its request,
    // so that a handover never costs a dead cycle.
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (m0_req && m1_req) begin
`ifdef RAM_ARB_RR_EN
      pick0 = last_q;
      pick1 = ~last_q;
`else
      pick0 = 1'b1;
`endif
    end else begin
      pick0 = m0_req;
      pick1 = m1_req;
    end

    gnt0     = 1'b0;
    gnt1     = 1'b0;
    owner_d  = OWN_NONE;
    cnt_d    = '0;
    reselect = 1'b0;

    unique case (owner_q)
      OWN_P0: begin
        if (!m0_req) begin
          reselect = 1'b1;
        end else if (!m1_req || cnt_q < CNT_LAST) begin
          gnt0    = 1'b1;
          owner_d = OWN_P0;
          // Saturates while the other port is idle, so a late arrival on the
          // other port takes over at once.
          cnt_d   = (cnt_q < CNT_LAST) ? cnt_q + 1'b1 : cnt_q;
        end else begin
          gnt1    = 1'b1;
          owner_d = OWN_P1;
        end
      end
      OWN_P1: begin
        if (!m1_req) begin
          reselect = 1'b1;
        end else if (!m0_req || cnt_q < CNT_LAST) begin
          gnt1    = 1'b1;
          owner_d = OWN_P1;
          cnt_d   = (cnt_q < CNT_LAST) ? cnt_q + 1'b1 : cnt_q;
        end else begin
          gnt0    = 1'b1;
          owner_d = OWN_P0;
        end
      end
      default: reselect = 1'b1;
    endcase

    if (reselect) begin
      gnt0    = pick0;
      gnt1    = pick1;
      owner_d = pick0 ? OWN_P0 : (pick1 ? OWN_P1 : OWN_NONE);
    end

    // No grant may leak out while reset is held.
    gnt0 = gnt0 & rst_n;
    gnt1 = gnt1 & rst_n;

    m0_rvalid_d = gnt0 & ~m0_we;
    m1_rvalid_d = gnt1 & ~m1_we;

`ifdef RAM_ARB_RR_EN
    last_d = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_q);
`endif
  end

  // Outputs
  always_comb begin
    m0_gnt    = gnt0;
    m1_gnt    = gnt1;
    m0_rvalid = m0_rvalid_q;
    m1_rvalid = m1_rvalid_q;
    rdata     = ram_dout;
    ram_addr  = '0;
    ram_din   = '0;
    ram_we    = 1'b0;
    if (gnt0) begin
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
      ram_we   = m0_we;
    end else if (gnt1) begin
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
      ram_we   = m1_we;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] rdata, ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  ram_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic clear_reqs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  // Leaves the bench 1 time unit after a posedge with reset released.
  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst_n = 1'b0;
    m0_req = 1'b1; m0_addr = 16'd64;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'd3; m1_wdata = 16'hBEEF;
    repeat (2) @(posedge clk); #1;
    total++; if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    total++; if (ram_we !== 1'b0 || ram_addr !== 16'h0 || ram_din !== 16'h0) begin bad++; $display("FAIL rst_ram: we=%b addr=%h din=%h want 0/0/0", ram_we, ram_addr, ram_din); end
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
    clear_reqs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (mem[3] !== 16'hA003) begin bad++; $display("FAIL rst_mem3: got %h want a003", mem[3]); end
  endtask

  task automatic test_read64();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'd64;
    #1;
    total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL rd64_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    total++; if (ram_addr !== 16'd64 || ram_we !== 1'b0) begin bad++; $display("FAIL rd64_ram: addr=%h we=%b want 0040/0", ram_addr, ram_we); end
    @(posedge clk); #1;
    clear_reqs();
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin bad++; $display("FAIL rd64_rvalid: got %b want 10", {m0_rvalid, m1_rvalid}); end
    total++; if (rdata !== 16'hFFFE) begin bad++; $display("FAIL rd64_data: got %h want fffe", rdata); end
    @(posedge clk); #1;
    total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL rd64_single: got %b want 0", m0_rvalid); end
  endtask

  task automatic test_tie();
    logic [1:0] exp2;
    do_reset();
    m0_req = 1'b1; m0_addr = 16'd10;
    m1_req = 1'b1; m1_addr = 16'd11;
    #1;
    total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL tie1: got %b want 10", {m0_gnt, m1_gnt}); end
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 16'd10;
    m1_req = 1'b1; m1_addr = 16'd11;
    #1;
`ifdef RAM_ARB_RR_EN
    exp2 = 2'b01;
`else
    exp2 = 2'b10;
`endif
    total++; if ({m0_gnt, m1_gnt} !== exp2) begin bad++; $display("FAIL tie2: got %b want %b", {m0_gnt, m1_gnt}, exp2); end
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    logic exp0, prev0;
    do_reset();
    m0_req = 1'b1; m0_addr = 16'd20;
    m1_req = 1'b1; m1_addr = 16'd21;
    prev0 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp0 = ((c / 4) % 2) == 0;
      total++; if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin bad++; $display("FAIL burst_gnt[%0d]: got %b%b want %b%b", c, m0_gnt, m1_gnt, exp0, !exp0); end
      if (c > 0) begin
        total++; if (m0_rvalid !== prev0 || m1_rvalid !== !prev0) begin bad++; $display("FAIL burst_rvalid[%0d]: got %b%b want %b%b", c, m0_rvalid, m1_rvalid, prev0, !prev0); end
      end
      prev0 = exp0;
      @(posedge clk);
    end
    #1 clear_reqs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'd7;
    #1;
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", m0_gnt); end
    @(posedge clk); #1;
    total++; if (m0_rvalid !== 1'b1) begin bad++; $display("FAIL mid_rvalid_pre: got %b want 1", m0_rvalid); end
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'd7; m1_wdata = 16'hDEAD;
    #1 rst_n = 1'b0;
    #1;
    total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid_rst: got %b want 0", m0_rvalid); end
    total++; if ({m0_gnt, m1_gnt, ram_we} !== 3'b000) begin bad++; $display("FAIL mid_gnt_we_rst: got %b want 000", {m0_gnt, m1_gnt, ram_we}); end
    @(posedge clk); #1;
    total++; if (mem[7] !== 16'hA007) begin bad++; $display("FAIL mid_mem: got %h want a007", mem[7]); end
    clear_reqs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Owner must be NONE: a tie now resolves to port 0 in both builds.
    m0_req = 1'b1; m0_addr = 16'd7;
    m1_req = 1'b1; m1_addr = 16'd8;
    #1;
    total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL mid_owner: got %b want 10", {m0_gnt, m1_gnt}); end
    @(posedge clk); #1;
    clear_reqs();
    total++; if (m0_rvalid !== 1'b1 || rdata !== 16'hA007) begin bad++; $display("FAIL mid_readback: rvalid=%b data=%h want 1/a007", m0_rvalid, rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_m1_stream();
    logic [DW-1:0] expd;
    for (int i = 0; i < 10; i++) begin
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = AW'(i);
      #1;
      total++; if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL stream_gnt[%0d]: got %b want 01", i, {m0_gnt, m1_gnt}); end
      if (i > 0) begin
        expd = 16'hA000 + DW'(i - 1);
        total++; if (m1_rvalid !== 1'b1 || rdata !== expd) begin bad++; $display("FAIL stream_data[%0d]: rvalid=%b data=%h want 1/%h", i - 1, m1_rvalid, rdata, expd); end
      end
      @(posedge clk); #1;
    end
    clear_reqs();
    total++; if (m1_rvalid !== 1'b1 || rdata !== 16'hA009) begin bad++; $display("FAIL stream_data[9]: rvalid=%b data=%h want 1/a009", m1_rvalid, rdata); end
    @(posedge clk); #1;
    total++; if (m1_rvalid !== 1'b0) begin bad++; $display("FAIL stream_end: got %b want 0", m1_rvalid); end
  endtask

  task automatic test_write_read();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'd5; m1_wdata = 16'h1234;
    #1;
    total++; if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL wr_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
    total++; if (ram_we !== 1'b1 || ram_addr !== 16'd5 || ram_din !== 16'h1234) begin bad++; $display("FAIL wr_ram: we=%b addr=%h din=%h want 1/0005/1234", ram_we, ram_addr, ram_din); end
    @(posedge clk); #1;
    clear_reqs();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'd5;
    #1;
    total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL rd5_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    total++; if (m1_rvalid !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid: got %b want 0", m1_rvalid); end
    @(posedge clk); #1;
    clear_reqs();
    total++; if (m0_rvalid !== 1'b1 || rdata !== 16'h1234) begin bad++; $display("FAIL rd5_data: rvalid=%b data=%h want 1/1234", m0_rvalid, rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_reqs();
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    for (int i = 0; i < 10; i++) mem[i] <= 16'hA000 + DW'(i);
    mem[64] <= 16'hFFFE;

    test_reset();
    test_read64();
    test_tie();
    test_burst();
    test_reset_mid_read();
    test_m1_stream();
    test_write_read();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
